// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types (package)
// Description : Result and broadcast payload types shared by the CDB arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    localparam int ROB_DEPTH = 16;
    localparam int FU_COUNT  = 4;
    localparam int PREG_W    = 6;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
    } rvfi_t;

    typedef struct packed {
        logic [$clog2(ROB_DEPTH)-1:0] rob_id;
        logic [PREG_W-1:0]            pd;
        logic [4:0]                   rd;
        logic [31:0]                  value;
        rvfi_t                        rvfi;
    } fu_result_t;

    typedef fu_result_t cdb_t;

endpackage

`default_nettype wire

// File: rtl/cdb_rr_select.sv
// ============================================================================
// Module      : cdb_rr_select
// Description : Combinational picker: starved requesters first, then the rest,
//               both scanned from the round-robin pointer; up to N_LANES picks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_rr_select
    import rv32i_types::*;
#(
    parameter int N_REQ   = 4,
    parameter int N_LANES = 2,
    parameter int IDX_W   = 2
) (
    input  logic [N_REQ-1:0]              i_req,
    input  logic [N_REQ-1:0]              i_prio,
    input  logic [IDX_W-1:0]              i_rr_ptr,
    output logic [N_REQ-1:0]              o_grant,
    output logic [N_LANES-1:0]            o_lane_valid,
    output logic [N_LANES-1:0][IDX_W-1:0] o_lane_idx
);

    always_comb begin
        int n;
        int idx;
        logic want;
        o_grant      = '0;
        o_lane_valid = '0;
        o_lane_idx   = '0;
        n            = 0;
        idx          = 0;
        want         = 1'b0;
        // Pass 0 takes starved requesters, pass 1 everyone else.
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(i_rr_ptr) + k;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                want = (pass == 0) ? i_prio[idx] : !i_prio[idx];
                if (i_req[idx] && want && (n < N_LANES)) begin
                    o_grant[idx]    = 1'b1;
                    o_lane_valid[n] = 1'b1;
                    o_lane_idx[n]   = IDX_W'(idx);
                    n               = n + 1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module      : cdb_arbiter
// Description : Shares SS common-data-bus lanes among FU result ports with
//               round-robin grants, starvation override and a 1-cycle CDB stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int SS           = 2,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [FU_COUNT-1:0]       fu_valid,
    input  fu_result_t [FU_COUNT-1:0] fu_result,
    output logic [FU_COUNT-1:0]       fu_ready,
    output logic [SS-1:0]             cdb_valid,
    output cdb_t [SS-1:0]             cdb_out
);

    localparam int C_IDX_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
    localparam int C_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(STARVE_LIMIT);
    localparam logic [C_IDX_W-1:0] C_LAST  = C_IDX_W'(FU_COUNT - 1);

    logic [C_IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [FU_COUNT-1:0][C_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [SS-1:0]                    cdb_valid_q, cdb_valid_d;
    cdb_t [SS-1:0]                    cdb_out_q, cdb_out_d;

    logic                             w_accept;
    logic [FU_COUNT-1:0]              w_prio;
    logic [FU_COUNT-1:0]              w_grant;
    logic [SS-1:0]                    w_lane_valid;
    logic [SS-1:0][C_IDX_W-1:0]       w_lane_idx;
    logic [C_IDX_W-1:0]               w_last;

    assign w_accept = !rst && !flush;

    always_comb begin
        w_prio = '0;
        for (int j = 0; j < FU_COUNT; j++) begin
            w_prio[j] = fu_valid[j] && (wait_cnt_q[j] >= C_LIMIT);
        end
    end

    cdb_rr_select #(
        .N_REQ   (FU_COUNT),
        .N_LANES (SS),
        .IDX_W   (C_IDX_W)
    ) u_select (
        .i_req        (fu_valid),
        .i_prio       (w_prio),
        .i_rr_ptr     (rr_ptr_q),
        .o_grant      (w_grant),
        .o_lane_valid (w_lane_valid),
        .o_lane_idx   (w_lane_idx)
    );

    always_comb begin
        fu_ready    = w_accept ? w_grant : '0;
        rr_ptr_d    = rr_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        cdb_valid_d = '0;
        cdb_out_d   = cdb_out_q;
        w_last      = '0;

        for (int k = 0; k < SS; k++) begin
            if (w_lane_valid[k]) begin
                w_last = w_lane_idx[k];
            end
        end
        // Explicit wrap keeps this correct for non-power-of-2 FU counts.
        if (w_accept && (|w_lane_valid)) begin
            rr_ptr_d = (w_last == C_LAST) ? '0 : w_last + 1'b1;
        end

        for (int j = 0; j < FU_COUNT; j++) begin
            if (!w_accept || !fu_valid[j] || w_grant[j]) begin
                wait_cnt_d[j] = '0;
            end else if (wait_cnt_q[j] < C_LIMIT) begin
                wait_cnt_d[j] = wait_cnt_q[j] + 1'b1;
            end
        end

        if (w_accept) begin
            for (int k = 0; k < SS; k++) begin
                if (w_lane_valid[k]) begin
                    cdb_valid_d[k] = 1'b1;
                    cdb_out_d[k]   = fu_result[w_lane_idx[k]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            wait_cnt_q  <= '0;
            cdb_valid_q <= '0;
            cdb_out_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_out_q   <= cdb_out_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_out   = cdb_out_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Randomised scoreboard bench; unit 0 uses the default starvation
//               limit, unit 1 a limit of 1 so the override path is exercised.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
    import rv32i_types::*;

    localparam int SS = 2;
    localparam int NU = 2;

    typedef struct packed {
        int                   cyc;
        logic [SS-1:0]        vld;
        fu_result_t [SS-1:0]  lane;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [NU-1:0][FU_COUNT-1:0]       fu_valid;
    fu_result_t [NU-1:0][FU_COUNT-1:0] fu_result;
    wire  [NU-1:0][FU_COUNT-1:0]       fu_ready;
    wire  [NU-1:0][SS-1:0]             cdb_valid;
    wire  fu_result_t [NU-1:0][SS-1:0] cdb_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int                           rr_m   [NU];
    int                           wt_m   [NU][FU_COUNT];
    fu_result_t [NU-1:0][SS-1:0]  hold_m;
    exp_t                         sbq    [NU][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar u = 0; u < NU; u++) begin : g_dut
        cdb_arbiter #(
            .SS           (SS),
            .STARVE_LIMIT ((u == 0) ? 7 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .fu_valid  (fu_valid[u]),
            .fu_result (fu_result[u]),
            .fu_ready  (fu_ready[u]),
            .cdb_valid (cdb_valid[u]),
            .cdb_out   (cdb_out[u])
        );
    end

    function automatic int limit_of(input int u);
        return (u == 0) ? 7 : 1;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic fu_result_t rand_res();
        fu_result_t r;
        r.rob_id     = 4'($urandom);
        r.pd         = 6'($urandom);
        r.rd         = 5'($urandom);
        r.value      = $urandom;
        r.rvfi.valid = 1'($urandom);
        r.rvfi.order = {$urandom, $urandom};
        r.rvfi.insn  = $urandom;
        return r;
    endfunction

    // Reference: starved requesters (in scan order) go first, then the rest.
    task automatic model_step(input int u);
        int lim;
        int j;
        int ng;
        int starved[$];
        int normal[$];
        int order[$];
        logic [FU_COUNT-1:0] er;
        exp_t e;
        lim = limit_of(u);
        er  = '0;
        if (rst) begin
            rr_m[u]   = 0;
            hold_m[u] = '0;
            for (int k = 0; k < FU_COUNT; k++) wt_m[u][k] = 0;
        end else if (flush) begin
            for (int k = 0; k < FU_COUNT; k++) wt_m[u][k] = 0;
        end else begin
            for (int k = 0; k < FU_COUNT; k++) begin
                j = (rr_m[u] + k) % FU_COUNT;
                if (fu_valid[u][j]) begin
                    if (wt_m[u][j] >= lim) starved.push_back(j);
                    else                   normal.push_back(j);
                end
            end
            order = {starved, normal};
            ng    = (order.size() < SS) ? order.size() : SS;
            e.cyc = cyc + 1;
            e.vld = '0;
            for (int k = 0; k < ng; k++) begin
                er[order[k]] = 1'b1;
                e.vld[k]     = 1'b1;
                hold_m[u][k] = fu_result[u][order[k]];
            end
            e.lane = hold_m[u];
            if (ng > 0) begin
                rr_m[u] = (order[ng-1] + 1) % FU_COUNT;
                sbq[u].push_back(e);
            end
            for (int k = 0; k < FU_COUNT; k++) begin
                if (fu_valid[u][k] && !er[k]) wt_m[u][k] = (wt_m[u][k] + 1 > lim) ? lim : wt_m[u][k] + 1;
                else                          wt_m[u][k] = 0;
            end
        end
        chk($sformatf("fu_ready[u%0d]", u), 512'(fu_ready[u]), 512'(er));
    endtask

    task automatic monitor_step(input int u);
        exp_t e;
        while (sbq[u].size() != 0 && sbq[u][0].cyc < cyc) begin
            e = sbq[u].pop_front();
            chk($sformatf("cdb_missing[u%0d]", u), 512'(0), 512'(e.vld));
        end
        if (cdb_valid[u] != '0) begin
            if (sbq[u].size() == 0 || sbq[u][0].cyc != cyc) begin
                chk($sformatf("cdb_unexpected[u%0d]", u), 512'(cdb_valid[u]), 512'(0));
            end else begin
                e = sbq[u].pop_front();
                chk($sformatf("cdb_valid[u%0d]", u), 512'(cdb_valid[u]), 512'(e.vld));
                chk($sformatf("cdb_out[u%0d]", u), 512'(cdb_out[u]), 512'(e.lane));
            end
        end
    endtask

    always @(negedge clk) begin : p_model
        for (int u = 0; u < NU; u++) model_step(u);
    end

    always @(negedge clk) begin : p_monitor
        for (int u = 0; u < NU; u++) monitor_step(u);
    end

    task automatic drive(input logic [FU_COUNT-1:0] pat, input logic fl, input logic rs);
        @(posedge clk);
        #1;
        rst   = rs;
        flush = fl;
        for (int u = 0; u < NU; u++) begin
            for (int j = 0; j < FU_COUNT; j++) begin
                fu_valid[u][j]  = pat[j];
                fu_result[u][j] = rand_res();
            end
        end
    endtask

    initial begin : p_stim
        logic [NU-1:0][FU_COUNT-1:0] gr;
        rst       = 1'b1;
        flush     = 1'b0;
        fu_valid  = '0;
        fu_result = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        repeat (3) begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                chk($sformatf("idle_cdb_valid[u%0d]", u), 512'(cdb_valid[u]), 512'(0));
                chk($sformatf("idle_fu_ready[u%0d]", u), 512'(fu_ready[u]), 512'(0));
            end
        end

        drive(4'b1111, 1'b0, 1'b0);
        drive(4'b1111, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, 1'b0);
        drive(4'b1001, 1'b0, 1'b0);
        for (int u = 0; u < NU; u++) begin
            fu_result[u][3].rob_id = 4'd5;
            fu_result[u][0].rob_id = 4'd6;
        end
        drive(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("wrap_lane0_rob[u%0d]", u), 512'(cdb_out[u][0].rob_id), 512'(5));
            chk($sformatf("wrap_lane1_rob[u%0d]", u), 512'(cdb_out[u][1].rob_id), 512'(6));
        end

        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("flush_cdb_valid[u%0d]", u), 512'(cdb_valid[u]), 512'(0));
        end

        repeat (3000) begin
            @(negedge clk);
            gr = fu_ready;
            @(posedge clk);
            #1;
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 24) == 0);
            for (int u = 0; u < NU; u++) begin
                for (int j = 0; j < FU_COUNT; j++) begin
                    if (!fu_valid[u][j] || gr[u][j]) begin
                        fu_valid[u][j]  = ($urandom_range(0, 9) < 6);
                        fu_result[u][j] = rand_res();
                    end
                end
            end
        end

        drive(4'b0000, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("drain[u%0d]", u), 512'(sbq[u].size()), 512'(0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
